// File: rtl/mem_pkg.sv
// Shared types and defaults for the multi-cycle memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_DATA_W  = 32;

  // The WAIT counter starts at LATENCY-2, so it must hold values up to LATENCY-2.
  function automatic int cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat - 1) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_LATENCY);

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word array: synchronous write, registered synchronous read with clear.
module mem_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Only reads touch the output register, so writes leave the last read data intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/multicycle_mem_resp.sv
// Fixed-latency single-port memory responder for the multi-cycle datapath.
// Optional alignment fault checking is compiled in with MEM_ALIGN_CHECK_EN.
module multicycle_mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CW    = cnt_width(LATENCY);

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                we_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                capture;
  logic                acc_en;
  logic                acc_we;
  logic [IDX_W-1:0]    acc_idx;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_fault;
  logic                in_fault;
  logic [IDX_W-1:0]    in_idx;
  logic                unused_addr;

  assign in_idx      = addr[IDX_W+1:2];
  assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            acc_en     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
          acc_en     = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY==1 the access edge is the capture edge, so use the live inputs.
  assign acc_we    = (state_reg == IDLE) ? we     : we_reg;
  assign acc_idx   = (state_reg == IDLE) ? in_idx : idx_reg;
  assign acc_wdata = (state_reg == IDLE) ? wdata  : wdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        we_reg    <= we;
        idx_reg   <= in_idx;
        wdata_reg <= wdata;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic fault_reg;

  assign in_fault = |addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_reg <= 1'b0;
    end else if (capture) begin
      fault_reg <= in_fault;
    end
  end

  assign acc_fault = (state_reg == IDLE) ? in_fault : fault_reg;
  assign err       = (state_reg == RESP) & fault_reg;
`else
  assign in_fault  = 1'b0;
  assign acc_fault = in_fault;
  assign err       = 1'b0;
`endif

  assign ready = (state_reg == RESP);
  assign busy  = (state_reg != IDLE);

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (acc_en & acc_we & ~acc_fault),
    .re    (acc_en & ~acc_we & ~acc_fault),
    .clr   (acc_en & ~acc_we & acc_fault),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_multicycle_mem_resp.sv
// Scoreboard bench for multicycle_mem_resp (LATENCY=2 main instance, LATENCY=1 side instance).
module tb_multicycle_mem_resp;

  localparam int LAT = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready, err, busy;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ready1, err1, busy1;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [64];
  int          total = 0;
  int          bad = 0;
  int          pulses = 0;

  multicycle_mem_resp #(.DEPTH(64), .LATENCY(LAT), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  multicycle_mem_resp #(.DEPTH(64), .LATENCY(1), .DATA_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  exp_t mon_e;
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      pulses++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ready: ready=1 with no pending request");
      end else begin
        mon_e = sb.pop_front();
        if (err !== mon_e.err || (mon_e.chk && rdata !== mon_e.data)) begin
          bad++;
          $display("FAIL resp: got rdata=%h err=%b, required rdata=%h err=%b (data checked=%0b)",
                   rdata, err, mon_e.data, mon_e.err, mon_e.chk);
        end else begin
          $display("resp ok: rdata=%h err=%b", rdata, err);
        end
      end
    end
  end

  task automatic push_exp(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic fault;
    fault = ALIGN && (a[1:0] != 2'b00);
    e.err = fault;
    if (w) begin
      if (!fault) model[a[7:2]] = d;
      e.chk  = 1'b0;
      e.data = '0;
    end else begin
      e.chk  = 1'b1;
      e.data = fault ? 32'h0 : model[a[7:2]];
    end
    sb.push_back(e);
  endtask

  // Issues one request and checks ready/busy timing through the return to IDLE.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    push_exp(w, a, d);
    we = w; addr = a; wdata = d; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      total++;
      if (ready !== 1'(k == LAT) || busy !== 1'(k <= LAT)) begin
        bad++;
        $display("FAIL latency: addr=%h cycle=%0d got ready=%b busy=%b, required ready=%b busy=%b",
                 a, k, ready, busy, 1'(k == LAT), 1'(k <= LAT));
      end
      if (k <= LAT) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
        bad++;
        $display("FAIL reset_state: cycle=%0d got ready=%b err=%b busy=%b rdata=%h, required all 0",
                 i, ready, err, busy, rdata);
      end
    end
    $display("reset check done");
  endtask

  task automatic test_basic();
    access(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_back_to_back();
    int got;
    int start;
    access(1'b1, 32'h00, 32'd1);
    access(1'b1, 32'h04, 32'd2);
    access(1'b1, 32'h08, 32'd3);
    push_exp(1'b0, 32'h00, 32'h0);
    push_exp(1'b0, 32'h04, 32'h0);
    push_exp(1'b0, 32'h08, 32'h0);
    got = 0;
    start = pulses;
    we = 1'b0; addr = 32'h00; req = 1'b1;
    // req stays high throughout; it must only be taken while idle
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got++;
        addr = 32'(got * 4);
        if (got == 3) req = 1'b0;
      end
    end
    req = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    total++;
    if (got != 3 || pulses - start != 3) begin
      bad++;
      $display("FAIL back_to_back: got %0d pulses, required 3", pulses - start);
    end
  endtask

  task automatic test_wrap();
    access(1'b1, 32'h104, 32'h55);
    access(1'b0, 32'h004, 32'h0);
  endtask

  task automatic test_abort();
    access(1'b1, 32'h20, 32'h11);
    we = 1'b1; addr = 32'h20; wdata = 32'hAA; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    total++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_wait: got busy=%b ready=%b, required busy=1 ready=0", busy, ready);
    end
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got busy=%b ready=%b, required busy=0 ready=0", busy, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    access(1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_align();
    access(1'b1, 32'h22, 32'h77);
    access(1'b0, 32'h20, 32'h0);
    access(1'b0, 32'h22, 32'h0);
  endtask

  task automatic test_latency1();
    we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h12345678; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    total++;
    if (ready1 !== 1'b1 || busy1 !== 1'b1 || err1 !== 1'b0) begin
      bad++;
      $display("FAIL lat1_write: got ready=%b busy=%b err=%b, required 1 1 0", ready1, busy1, err1);
    end
    @(negedge clk);
    total++;
    if (ready1 !== 1'b0 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL lat1_idle: got ready=%b busy=%b, required 0 0", ready1, busy1);
    end
    we1 = 1'b0; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req1 = 1'b0;
    total++;
    if (ready1 !== 1'b1 || rdata1 !== 32'h12345678) begin
      bad++;
      $display("FAIL lat1_read: got ready=%b rdata=%h, required ready=1 rdata=12345678", ready1, rdata1);
    end else begin
      $display("lat1 read ok: rdata=%h", rdata1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrap();
    test_abort();
    test_align();
    test_latency1();
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d responses outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
